refresh_clkgen_multi: RTL
=========================

Name: refresh_clkgen_multi

Overview:
- Parametrised multi-channel clock-enable generator that succeeds the single-output fixed-frequency refresh PLL wrapper.
- Each channel has a runtime-programmable phase accumulator (NCO) running on refclk. The accumulator produces a pixel/refresh enable pulse, a divided square-wave clock and a per-channel lock indication.
- Video timing blocks switch refresh rates through a valid/ready config port without re-synthesising a PLL.
- Retunes are applied glitch-free, only at a channel's accumulator wrap.

Parameters:
- NUM_CLOCKS, 4: number of independent output channels (1..16).
- ACC_WIDTH, 24: phase accumulator and increment width. f_en = f_refclk * incr / 2^ACC_WIDTH.
- LOCK_CYCLES, 1024: refclk cycles after a config is applied before locked[i] asserts (>=1).
- DEFAULT_INCR, 0: increment loaded into every channel at reset.
- DEFAULT_ENABLE, 0: enable state of every channel at reset (1 = all enabled).
- SEL_W, max(1, clog2(NUM_CLOCKS)): width of cfg_sel.

Ports:
- refclk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset.
- cfg_valid  in  1  config request valid.
- cfg_ready  out  1  config slot free; a transfer occurs when cfg_valid && cfg_ready at a refclk edge.
- cfg_sel  in  SEL_W  target channel.
- cfg_incr  in  ACC_WIDTH  new increment.
- cfg_enable  in  1  new enable state for the target channel.
- outclk_en  out  NUM_CLOCKS  one-cycle pulse per accumulator carry.
- outclk  out  NUM_CLOCKS  toggles on each carry; frequency is f_en/2.
- locked  out  NUM_CLOCKS  channel settled.
- locked_all  out  1  AND of locked over all enabled channels; 0 if no channel is enabled.

Behaviour:
- Reset (rst==0 at an edge):
  - acc=0, incr=DEFAULT_INCR, en=DEFAULT_ENABLE, pending=0, settle counters=0.
  - outclk_en=0, outclk=0, locked=0, locked_all=0, cfg_ready=0.
  - cfg_ready goes to 1 on the first edge with rst==1.
  - Any pending config is discarded.
- Per-channel datapath, every edge while en[i]:
  - {carry, acc_next} = acc + incr, computed (ACC_WIDTH+1) bits wide; acc <= low ACC_WIDTH bits.
  - outclk_en[i] <= carry, i.e. the pulse is registered and visible the cycle after the carrying add.
  - outclk[i] toggles on the same edge that sets outclk_en[i].
  - Unsigned wrap is intentional; no saturation.
- Disabled channel (en[i]==0): acc held at 0, outclk_en[i]=0, outclk[i]=0, locked[i]=0.
- Config handshake:
  - cfg_ready = !pending.
  - At transfer edge k: {sel, incr, enable} is captured into a single pending register and cfg_ready drops.
  - If cfg_sel >= NUM_CLOCKS, the transfer is accepted and discarded; pending stays 0 and cfg_ready stays 1.
- Apply rule, evaluated every edge while pending:
  - Apply immediately (edge k+1) if the target channel is currently disabled, its current incr==0, or the new cfg_enable==0.
  - Otherwise apply on the edge where the target channel's add produces carry. That add uses the old incr; the new incr is used from the next add, so phase is continuous.
  - On the apply edge: incr/en are updated, the settle counter is cleared, locked[i] <= 0 and pending is cleared. cfg_ready is 1 from the following cycle.
  - If the applied enable==0: acc, outclk and outclk_en are cleared on the apply edge.
  - A new transfer cannot coincide with an apply edge, because cfg_ready is low in that cycle.
- Lock:
  - Per-channel counter of width clog2(LOCK_CYCLES+1).
  - Increments while en[i] && incr!=0; saturates at LOCK_CYCLES.
  - locked[i] = (count==LOCK_CYCLES), registered; the first 1 appears LOCK_CYCLES edges after the apply edge.
  - Held at 0 while incr==0.
- Reset mid-operation overrides everything, including an apply on the same edge.

Test Plan (ACC_WIDTH=8, LOCK_CYCLES=16, NUM_CLOCKS=4, DEFAULT_INCR=0, DEFAULT_ENABLE=0):
1. Hold rst=0 for 3 edges, then release -> all outputs 0 during reset; cfg_ready=1 after the first released edge; no outclk_en pulses for 100 cycles.
2. Config ch0 incr=64 enable=1 -> applied 1 edge after transfer; outclk_en[0] pulses every 4 cycles; outclk[0] period is 8 cycles; locked[0]=1 exactly 16 edges after apply; locked_all=1.
3. Config ch1 incr=96 -> accumulator sequence 96,192,32c,128,224,64c,160,0c; pulse spacing repeats 3,3,2 (3 pulses per 8 cycles).
4. With ch0 running at 64, program incr=128 -> cfg_ready stays low until ch0's next carry edge; apply occurs there; subsequent pulses every 2 cycles with no gap <2 or >4 at the switch; locked[0] drops on the apply edge and re-asserts 16 edges later.
5. Disable ch1 mid-run (cfg_enable=0) -> next edge outclk[1]=0, no further outclk_en[1], locked[1]=0; locked_all reflects only ch0.
6. Hold cfg_valid with cfg_sel=5 -> accepted every cycle and discarded, cfg_ready stays 1. Separately, assert rst while a config is pending -> pending dropped; after release incr=0 and en=0 on all channels.

Source files
------------

// File: rtl/refresh_clkgen_multi.sv
// refresh_clkgen_multi: per-channel NCO clock-enable generator
// with one config slot that retunes a channel at its wrap.
module refresh_clkgen_multi #(
  parameter int NUM_CLOCKS = 4,
  parameter int ACC_WIDTH = 24,
  parameter int LOCK_CYCLES = 1024,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_INCR = '0,
  parameter bit DEFAULT_ENABLE = 1'b0,
  parameter int SEL_W =
    (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [SEL_W-1:0]      cfg_sel,
  input  logic [ACC_WIDTH-1:0]  cfg_incr,
  input  logic                  cfg_enable,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] locked,
  output logic                  locked_all
);

  localparam int CW = $clog2(LOCK_CYCLES + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_CYCLES);

  logic                  pending;
  logic                  p_en;
  logic [SEL_W-1:0]      p_sel;
  logic [ACC_WIDTH-1:0]  p_incr;
  logic [NUM_CLOCKS-1:0] apply;
  logic [NUM_CLOCKS-1:0] en;
  logic                  take;

  assign take = cfg_valid && cfg_ready &&
                (32'(cfg_sel) < NUM_CLOCKS);

  always_ff @(posedge refclk) begin
    if (!rst) begin
      pending   <= 1'b0;
      cfg_ready <= 1'b0;
      p_sel     <= '0;
      p_incr    <= '0;
      p_en      <= 1'b0;
    end else if (|apply) begin
      pending   <= 1'b0;
      cfg_ready <= 1'b1;
    end else if (take) begin
      pending   <= 1'b1;
      cfg_ready <= 1'b0;
      p_sel     <= cfg_sel;
      p_incr    <= cfg_incr;
      p_en      <= cfg_enable;
    end else begin
      cfg_ready <= !pending;
    end
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] incr;
    logic [ACC_WIDTH:0]   sum;
    logic [CW-1:0]        cnt;
    logic                 on;
    logic                 pulse;
    logic                 tog;
    logic                 live;

    assign sum  = {1'b0, acc} + {1'b0, incr};
    assign live = on && (incr != '0);

    // idle channels retune at once; live ones wait for carry
    assign apply[i] = pending &&
                      (p_sel == SEL_W'(i)) &&
                      (!live || !p_en || sum[ACC_WIDTH]);

    always_ff @(posedge refclk) begin
      if (!rst) begin
        acc   <= '0;
        incr  <= DEFAULT_INCR;
        on    <= DEFAULT_ENABLE;
        pulse <= 1'b0;
        tog   <= 1'b0;
        cnt   <= '0;
      end else begin
        if (on) begin
          acc   <= sum[ACC_WIDTH-1:0];
          pulse <= sum[ACC_WIDTH];
          if (sum[ACC_WIDTH]) tog <= ~tog;
        end else begin
          acc   <= '0;
          pulse <= 1'b0;
          tog   <= 1'b0;
        end
        if (live) begin
          if (cnt != LOCK_MAX) cnt <= cnt + CW'(1);
        end else begin
          cnt <= '0;
        end
        if (apply[i]) begin
          incr <= p_incr;
          on   <= p_en;
          cnt  <= '0;
          if (!p_en) begin
            acc   <= '0;
            pulse <= 1'b0;
            tog   <= 1'b0;
          end
        end
      end
    end

    assign outclk_en[i] = pulse;
    assign outclk[i]    = tog;
    assign locked[i]    = (cnt == LOCK_MAX);
    assign en[i]        = on;
  end

  assign locked_all = (|en) && (&(locked | ~en));

endmodule
